// File: rtl/rv_pkg.sv
// rv_pkg: shared register-file constants and the write-back entry payload.
//   XLEN       - default result width
//   REG_ADDR_W - architectural register address width
//   NUM_REGS   - number of architectural registers
//   wb_entry_t - {rd, data} write-back payload at the default XLEN
package rv_pkg;

    localparam int unsigned XLEN       = 32;
    localparam int unsigned REG_ADDR_W = 5;
    localparam int unsigned NUM_REGS   = 32;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] rd;
        logic [XLEN-1:0]       data;
    } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// wb_fifo: synchronous FIFO holding pending register-file writes.
//   clk, rst_n - clock, asynchronous active-low reset
//   push, din  - enqueue request and payload (ignored when full)
//   pop        - dequeue request (ignored when empty)
//   head_c     - combinational view of the oldest entry
//   full       - registered, occupancy == DEPTH
//   empty      - registered, occupancy == 0
//   count      - registered occupancy
module wb_fifo #(
    parameter int unsigned WIDTH = 37,
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic [WIDTH-1:0]           din,
    input  logic                       pop,
    output logic [WIDTH-1:0]           head_c,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count_nxt;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head_c  = mem[rd_ptr];

    // Next occupancy; a simultaneous push and pop leaves it unchanged.
    always_comb begin
        count_nxt = count;
        if (do_push && !do_pop) begin
            count_nxt = count + CNT_W'(1);
        end else if (!do_push && do_pop) begin
            count_nxt = count - CNT_W'(1);
        end
    end

    // Pointers and flags; pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count_nxt;
            full  <= (count_nxt == CNT_W'(DEPTH));
            empty <= (count_nxt == '0);
        end
    end

    // Storage needs no reset: the pointers define which entries are live.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/rf_write_ctrl.sv
// rf_write_ctrl: arbitrates ALU and load results into a write queue that
// drains into the register-file write port, and tracks outstanding writes.
//   clk, rst_n                     - clock, asynchronous active-low reset
//   alu_valid/ready, alu_rd/data   - ALU result handshake (lower priority)
//   lsu_valid/ready, lsu_rd/data   - load result handshake (higher priority)
//   wb_hold                        - blocks draining of the queue
//   issue_mark, issue_rd           - reserve rd for a pending write
//   pending                        - per-register outstanding-write scoreboard
//   WE, A3, WD3                    - registered register-file write port
//   count                          - queue occupancy
module rf_write_ctrl
    import rv_pkg::*;
#(
    parameter int unsigned XLEN  = rv_pkg::XLEN,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     alu_valid,
    output logic                     alu_ready,
    input  logic [REG_ADDR_W-1:0]    alu_rd,
    input  logic [XLEN-1:0]          alu_data,
    input  logic                     lsu_valid,
    output logic                     lsu_ready,
    input  logic [REG_ADDR_W-1:0]    lsu_rd,
    input  logic [XLEN-1:0]          lsu_data,
    input  logic                     wb_hold,
    input  logic                     issue_mark,
    input  logic [REG_ADDR_W-1:0]    issue_rd,
    output logic [NUM_REGS-1:0]      pending,
    output logic                     WE,
    output logic [REG_ADDR_W-1:0]    A3,
    output logic [XLEN-1:0]          WD3,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned ENTRY_W = REG_ADDR_W + XLEN;

    // Local payload type so that an XLEN override stays consistent.
    typedef struct packed {
        logic [REG_ADDR_W-1:0] rd;
        logic [XLEN-1:0]       data;
    } entry_t;

    entry_t              sel_entry_c;
    entry_t              head_entry_c;
    logic [ENTRY_W-1:0]  head_raw_c;
    logic                push_c;
    logic                pop_c;
    logic                fifo_full;
    logic                fifo_empty;
    logic                lsu_fire_c;
    logic                alu_fire_c;
    logic [NUM_REGS-1:0] pending_nxt;

    // Fixed priority: the load unit always wins the single enqueue slot.
    assign lsu_ready  = !fifo_full;
    assign alu_ready  = !fifo_full && !lsu_valid;
    assign lsu_fire_c = lsu_valid && lsu_ready;
    assign alu_fire_c = alu_valid && alu_ready;

    // Select the winning result; writes to x0 complete the handshake but are dropped.
    always_comb begin
        sel_entry_c = '0;
        push_c      = 1'b0;
        if (lsu_fire_c) begin
            sel_entry_c.rd   = lsu_rd;
            sel_entry_c.data = lsu_data;
        end else begin
            sel_entry_c.rd   = alu_rd;
            sel_entry_c.data = alu_data;
        end
        push_c = (lsu_fire_c || alu_fire_c) && (sel_entry_c.rd != '0);
    end

    assign pop_c        = !fifo_empty && !wb_hold;
    assign head_entry_c = entry_t'(head_raw_c);

    wb_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk    (clk),
        .rst_n  (rst_n),
        .push   (push_c),
        .din    (ENTRY_W'(sel_entry_c)),
        .pop    (pop_c),
        .head_c (head_raw_c),
        .full   (fifo_full),
        .empty  (fifo_empty),
        .count  (count)
    );

    // Register-file write port: one pulse per popped entry, address/data held otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            WE  <= 1'b0;
            A3  <= '0;
            WD3 <= '0;
        end else begin
            WE <= pop_c;
            if (pop_c) begin
                A3  <= head_entry_c.rd;
                WD3 <= head_entry_c.data;
            end
        end
    end

    // Scoreboard: clear on the edge the register file latches, then set (set wins).
    always_comb begin
        pending_nxt = pending;
        if (WE) pending_nxt[A3] = 1'b0;
        if (issue_mark && (issue_rd != '0)) pending_nxt[issue_rd] = 1'b1;
        pending_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending <= '0;
        end else begin
            pending <= pending_nxt;
        end
    end

endmodule

// File: tb/tb_rf_write_ctrl.sv
module tb_rf_write_ctrl;
    import rv_pkg::*;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    logic             clk;
    logic             rst_n;
    logic             alu_valid, alu_ready, lsu_valid, lsu_ready;
    logic [4:0]       alu_rd, lsu_rd, issue_rd, A3;
    logic [31:0]      alu_data, lsu_data, WD3, pending;
    logic             wb_hold, issue_mark, WE;
    logic [CNT_W-1:0] count;

    rf_write_ctrl #(.XLEN(32), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
        .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_rd(lsu_rd), .lsu_data(lsu_data),
        .wb_hold(wb_hold), .issue_mark(issue_mark), .issue_rd(issue_rd),
        .pending(pending), .WE(WE), .A3(A3), .WD3(WD3), .count(count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: a queue of accepted writes plus expected port values.
    wb_entry_t   mq[$];
    logic        m_we;
    logic [4:0]  m_a3;
    logic [31:0] m_wd3;
    logic [31:0] m_pend;
    int          errors = 0;
    int          checks = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_we = 1'b0; m_a3 = '0; m_wd3 = '0; m_pend = '0;
    endtask

    task automatic check_outputs(input string tag);
        chk({tag, ".count"},   64'(count),   64'(mq.size()));
        chk({tag, ".WE"},      64'(WE),      64'(m_we));
        chk({tag, ".A3"},      64'(A3),      64'(m_a3));
        chk({tag, ".WD3"},     64'(WD3),     64'(m_wd3));
        chk({tag, ".pending"}, 64'(pending), 64'(m_pend));
    endtask

    // One clock: drive inputs, check readies, advance, update model, check outputs.
    task automatic cycle(input string tag,
                         input logic av, input logic [4:0] ard, input logic [31:0] ad,
                         input logic lv, input logic [4:0] lrd, input logic [31:0] ld,
                         input logic hold, input logic mk, input logic [4:0] mrd);
        int        sz;
        logic      exp_lr, exp_ar;
        wb_entry_t e;
        alu_valid = av; alu_rd = ard; alu_data = ad;
        lsu_valid = lv; lsu_rd = lrd; lsu_data = ld;
        wb_hold = hold; issue_mark = mk; issue_rd = mrd;
        #1;
        sz     = mq.size();
        exp_lr = (sz < DEPTH);
        exp_ar = exp_lr && !lv;
        chk({tag, ".lsu_ready"}, 64'(lsu_ready), 64'(exp_lr));
        chk({tag, ".alu_ready"}, 64'(alu_ready), 64'(exp_ar));
        @(posedge clk);
        if (m_we) m_pend[m_a3] = 1'b0;
        if (mk && mrd != 0) m_pend[mrd] = 1'b1;
        if (sz > 0 && !hold) begin
            e = mq.pop_front();
            m_we = 1'b1; m_a3 = e.rd; m_wd3 = e.data;
        end else begin
            m_we = 1'b0;
        end
        if (sz < DEPTH) begin
            if (lv) begin
                if (lrd != 0) mq.push_back('{rd: lrd, data: ld});
            end else if (av && ard != 0) begin
                mq.push_back('{rd: ard, data: ad});
            end
        end
        #1;
        check_outputs(tag);
    endtask

    task automatic idle(input string tag, input int n, input logic hold);
        for (int i = 0; i < n; i++) cycle(tag, 0, 0, 0, 0, 0, 0, hold, 0, 0);
    endtask

    initial begin
        rst_n = 1'b0;
        alu_valid = 0; alu_rd = 0; alu_data = 0;
        lsu_valid = 0; lsu_rd = 0; lsu_data = 0;
        wb_hold = 0; issue_mark = 0; issue_rd = 0;
        model_reset();
        #12;
        check_outputs("reset");
        chk("reset.lsu_ready", 64'(lsu_ready), 64'(1));
        chk("reset.alu_ready", 64'(alu_ready), 64'(1));
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Single write, one-cycle WE pulse.
        cycle("single", 1, 5, 32'hDEADBEEF, 0, 0, 0, 0, 0, 0);
        cycle("single_we", 0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("single.WD3_const", 64'(WD3), 64'h0000_0000_DEAD_BEEF);
        chk("single.A3_const", 64'(A3), 64'd5);
        cycle("single_drop", 0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("single.WE_low", 64'(WE), 64'd0);

        // Contention: LSU first, ALU retried next cycle.
        cycle("cont", 1, 3, 32'h11, 1, 4, 32'h22, 0, 0, 0);
        cycle("cont2", 1, 3, 32'h11, 0, 0, 0, 0, 0, 0);
        idle("cont_drain", 3, 0);

        // Fill under hold, reject extra push, then drain including a full+pop cycle.
        for (int i = 1; i <= 4; i++)
            cycle("fill", 0, 0, 0, 1, 5'(i), 32'(32'h100 + i), 1, 0, 0);
        chk("fill.count_const", 64'(count), 64'd4);
        cycle("full_hold", 1, 9, 32'h99, 1, 9, 32'h99, 1, 0, 0);
        cycle("full_pop", 0, 0, 0, 1, 10, 32'hAA, 0, 0, 0);
        idle("drain", 5, 0);

        // x0 discard.
        cycle("x0", 0, 0, 0, 1, 0, 32'h1234, 0, 0, 0);
        idle("x0_after", 2, 0);

        // Scoreboard with set-wins on the clearing edge.
        cycle("sb_mark", 0, 0, 0, 0, 0, 0, 0, 1, 7);
        cycle("sb_push", 1, 7, 32'h77, 0, 0, 0, 0, 0, 0);
        cycle("sb_we", 0, 0, 0, 0, 0, 0, 0, 0, 0);
        cycle("sb_remark", 0, 0, 0, 0, 0, 0, 0, 1, 7);
        chk("sb.pending7_held", 64'(pending[7]), 64'd1);
        cycle("sb_push2", 0, 0, 0, 1, 7, 32'h78, 0, 0, 0);
        idle("sb_clear", 3, 0);
        chk("sb.pending7_clear", 64'(pending[7]), 64'd0);

        // Reset mid-flight with queued entries and pending bits.
        cycle("rst_q1", 1, 1, 32'hA1, 0, 0, 0, 1, 1, 1);
        cycle("rst_q2", 1, 2, 32'hA2, 0, 0, 0, 1, 1, 2);
        cycle("rst_q3", 1, 3, 32'hA3, 0, 0, 0, 1, 0, 0);
        rst_n = 1'b0;
        #2;
        model_reset();
        check_outputs("rst_mid");
        @(posedge clk); #1;
        rst_n = 1'b1;
        idle("rst_after", 4, 0);

        // Randomized traffic against the model.
        for (int i = 0; i < 400; i++) begin
            logic       av, lv, hold, mk;
            logic [4:0] ard, lrd, mrd;
            av   = 1'($urandom_range(0, 1));
            lv   = ($urandom_range(0, 2) == 0);
            ard  = 5'($urandom_range(0, 9));
            lrd  = 5'($urandom_range(0, 9));
            hold = ($urandom_range(0, 3) == 0);
            mrd  = 5'($urandom_range(0, 31));
            mk   = ($urandom_range(0, 2) == 0) && !m_pend[mrd];
            cycle("rand", av, ard, $urandom, lv, lrd, $urandom, hold, mk, mrd);
        end
        idle("final_drain", 6, 0);
        chk("final.count", 64'(count), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
